// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - long-latency scoreboard and register-file write-port arbiter
// Optional feature macro: WBSCHED_BYPASS_EN (RAW checks see a same-cycle long-latency writeback)
module regfile_wb_scheduler #(
    parameter int REG_NUM      = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int DATA_W       = 32,
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rd_we,
    input  logic                  id_long,
    output logic                  id_stall,
    input  logic                  pipe_wb_valid,
    input  logic [REG_ADDR_W-1:0] pipe_wb_addr,
    input  logic [DATA_W-1:0]     pipe_wb_data,
    input  logic                  lat_valid,
    output logic                  lat_ready,
    input  logic [REG_ADDR_W-1:0] lat_addr,
    input  logic [DATA_W-1:0]     lat_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_LIMIT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [REG_NUM-1:0]  pending, pending_next, set_vec, clr_vec;
    logic [CNT_W-1:0]    out_cnt, out_cnt_next;
    logic [STV_W-1:0]    starve_cnt, starve_cnt_next;

    logic lat_rdy_int, lat_hs, blocked;
    logic byp1, byp2, raw1, raw2, waw, full, stall_int, fire;
    logic set_en, dec_en, we_int;

    // WB cannot be back-pressured, so a long return only wins when WB is idle
    assign lat_rdy_int = !pipe_wb_valid;
    assign lat_hs      = lat_valid & lat_rdy_int;
    assign blocked     = lat_valid & !lat_rdy_int;

`ifdef WBSCHED_BYPASS_EN
    assign byp1 = lat_hs & (lat_addr == id_rs1_addr);
    assign byp2 = lat_hs & (lat_addr == id_rs2_addr);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign raw1 = id_rs1_used & (id_rs1_addr != '0) & pending[id_rs1_addr] & !byp1;
    assign raw2 = id_rs2_used & (id_rs2_addr != '0) & pending[id_rs2_addr] & !byp2;
    assign waw  = id_rd_we & (id_rd_addr != '0) & pending[id_rd_addr];
    assign full = id_long & id_rd_we & (out_cnt == CNT_MAX);

    assign stall_int = id_valid & (raw1 | raw2 | waw | full | (state == ST_DRAIN));
    assign fire      = id_valid & !stall_int;
    assign set_en    = fire & id_long & id_rd_we & (id_rd_addr != '0);
    assign dec_en    = lat_hs & pending[lat_addr];
    assign we_int    = pipe_wb_valid | (lat_hs & (lat_addr != '0));

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) begin
            set_vec[id_rd_addr] = 1'b1;
        end
        if (lat_hs) begin
            clr_vec[lat_addr] = 1'b1;
        end
        pending_next    = (pending & ~clr_vec) | set_vec;
        pending_next[0] = 1'b0;
    end

    always_comb begin
        out_cnt_next = out_cnt;
        case ({set_en, dec_en})
            2'b10:   out_cnt_next = out_cnt + 1'b1;
            2'b01:   out_cnt_next = out_cnt - 1'b1;
            default: out_cnt_next = out_cnt;
        endcase
    end

    // Starvation guard: a return blocked for STARVE_LIMIT cycles freezes issue until it lands
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (blocked) begin
                    if (starve_cnt == STV_LAST) begin
                        state_next = ST_DRAIN;
                    end else begin
                        starve_cnt_next = starve_cnt + 1'b1;
                    end
                end else begin
                    starve_cnt_next = '0;
                end
            end
            ST_DRAIN: begin
                if (lat_hs) begin
                    state_next      = ST_IDLE;
                    starve_cnt_next = '0;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                starve_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= '0;
            out_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            out_cnt    <= out_cnt_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Outputs are forced low for the whole time reset is asserted
    assign id_stall  = !rst & stall_int;
    assign lat_ready = !rst & lat_rdy_int;
    assign rf_we     = !rst & we_int;
    assign rf_waddr  = rst ? '0 : (pipe_wb_valid ? pipe_wb_addr : lat_addr);
    assign rf_wdata  = rst ? '0 : (pipe_wb_valid ? pipe_wb_data : lat_data);
    assign busy      = !rst & (|pending);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MAX_OUT = 4;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long, id_stall;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr, pipe_wb_addr, lat_addr, rf_waddr;
    logic pipe_wb_valid, lat_valid, lat_ready, rf_we, busy;
    logic [DW-1:0] pipe_wb_data, lat_data, rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
        .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_long(id_long), .id_stall(id_stall),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
        .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_addr(lat_addr), .lat_data(lat_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    // Reference: outstanding long writes as a list of register numbers
    int outq[$];
    bit m_drain;
    int m_blocked_run;
    bit e_stall, e_lr, e_we, e_busy, e_fire, e_hs;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit owned(logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        foreach (outq[i]) if (outq[i] == int'(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        outq.delete();
        m_drain = 1'b0;
        m_blocked_run = 0;
    endfunction

    function automatic void model_eval();
        bit raw, waw, full, byp1, byp2;
        e_lr = !pipe_wb_valid;
        e_hs = lat_valid && e_lr;
`ifdef WBSCHED_BYPASS_EN
        byp1 = e_hs && (lat_addr == id_rs1_addr);
        byp2 = e_hs && (lat_addr == id_rs2_addr);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        raw = (id_rs1_used && owned(id_rs1_addr) && !byp1) ||
              (id_rs2_used && owned(id_rs2_addr) && !byp2);
        waw = id_rd_we && owned(id_rd_addr);
        full = id_long && id_rd_we && (outq.size() == MAX_OUT);
        e_stall = id_valid && (raw || waw || full || m_drain);
        e_fire = id_valid && !e_stall;
        e_we = pipe_wb_valid || (e_hs && lat_addr != '0);
        e_wa = pipe_wb_valid ? pipe_wb_addr : lat_addr;
        e_wd = pipe_wb_valid ? pipe_wb_data : lat_data;
        e_busy = outq.size() != 0;
    endfunction

    function automatic void model_commit();
        int idx = -1;
        if (e_hs) begin
            foreach (outq[i]) if (idx < 0 && outq[i] == int'(lat_addr)) idx = i;
            if (idx >= 0) outq.delete(idx);
        end
        if (e_fire && id_long && id_rd_we && id_rd_addr != '0) outq.push_back(int'(id_rd_addr));
        if (m_drain) begin
            if (e_hs) begin
                m_drain = 1'b0;
                m_blocked_run = 0;
            end
        end else if (lat_valid && !e_lr) begin
            m_blocked_run++;
            if (m_blocked_run == STARVE_LIMIT) begin
                m_drain = 1'b1;
                m_blocked_run = 0;
            end
        end else begin
            m_blocked_run = 0;
        end
    endfunction

    task automatic tick(string tag);
        #1;
        model_eval();
        check($sformatf("%s.id_stall", tag), 32'(id_stall), 32'(e_stall));
        check($sformatf("%s.lat_ready", tag), 32'(lat_ready), 32'(e_lr));
        check($sformatf("%s.rf_we", tag), 32'(rf_we), 32'(e_we));
        check($sformatf("%s.busy", tag), 32'(busy), 32'(e_busy));
        if (e_we) begin
            check($sformatf("%s.rf_waddr", tag), 32'(rf_waddr), 32'(e_wa));
            check($sformatf("%s.rf_wdata", tag), rf_wdata, e_wd);
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rd_we = 0; id_long = 0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        pipe_wb_valid = 0; pipe_wb_addr = '0; pipe_wb_data = '0;
        lat_valid = 0; lat_addr = '0; lat_data = '0;
    endtask

    task automatic issue(bit lng, int rd, int rs1, bit rs1u);
        id_valid = 1; id_long = lng; id_rd_we = 1; id_rd_addr = AW'(rd);
        id_rs1_addr = AW'(rs1); id_rs1_used = rs1u; id_rs2_used = 0;
    endtask

    typedef struct {
        int idv; int rs1; int rs1u; int rs2; int rs2u; int rd; int rdwe; int lng;
        int wbv; int wba; int wbd; int latv; int lata; int latd;
        int x_stall; int x_lr; int x_we; int x_wa; int x_wd;
    } vec_t;
    vec_t vt[7];

    initial begin
        vt[0] = '{0,0,0,0,0,0,0,0, 0,0,0,            0,0,0,     0,1,0,0,0};
        vt[1] = '{0,0,0,0,0,0,0,0, 1,3,'h11,         1,7,'h22,  0,0,1,3,'h11};
        vt[2] = '{0,0,0,0,0,0,0,0, 0,0,0,            1,7,'h22,  0,1,1,7,'h22};
        vt[3] = '{0,0,0,0,0,0,0,0, 0,0,0,            1,0,'h33,  0,1,0,0,0};
        vt[4] = '{1,5,1,6,1,8,1,0, 0,0,0,            0,0,0,     0,1,0,0,0};
        vt[5] = '{0,0,0,0,0,0,0,0, 1,31,32'hFFFFFFFF, 1,9,'h44,  0,0,1,31,32'hFFFFFFFF};
        vt[6] = '{0,0,0,0,0,0,0,0, 1,0,5,            0,0,0,     0,0,1,0,5};

        model_reset();
        idle();
        rst = 1;
        pipe_wb_valid = 1; pipe_wb_addr = 5'd3; lat_valid = 1; lat_addr = 5'd4; id_valid = 1;
        #12;
        check("reset.id_stall", 32'(id_stall), 0);
        check("reset.lat_ready", 32'(lat_ready), 0);
        check("reset.rf_we", 32'(rf_we), 0);
        check("reset.busy", 32'(busy), 0);
        idle();
        @(posedge clk); #1;
        rst = 0;

        // Single-cycle arbitration vectors
        for (int i = 0; i < 7; i++) begin
            idle();
            id_valid = vt[i].idv[0]; id_rs1_addr = AW'(vt[i].rs1); id_rs1_used = vt[i].rs1u[0];
            id_rs2_addr = AW'(vt[i].rs2); id_rs2_used = vt[i].rs2u[0];
            id_rd_addr = AW'(vt[i].rd); id_rd_we = vt[i].rdwe[0]; id_long = vt[i].lng[0];
            pipe_wb_valid = vt[i].wbv[0]; pipe_wb_addr = AW'(vt[i].wba); pipe_wb_data = DW'(vt[i].wbd);
            lat_valid = vt[i].latv[0]; lat_addr = AW'(vt[i].lata); lat_data = DW'(vt[i].latd);
            #1;
            check($sformatf("vec%0d.id_stall", i), 32'(id_stall), 32'(vt[i].x_stall));
            check($sformatf("vec%0d.lat_ready", i), 32'(lat_ready), 32'(vt[i].x_lr));
            check($sformatf("vec%0d.rf_we", i), 32'(rf_we), 32'(vt[i].x_we));
            if (vt[i].x_we != 0) begin
                check($sformatf("vec%0d.rf_waddr", i), 32'(rf_waddr), 32'(vt[i].x_wa));
                check($sformatf("vec%0d.rf_wdata", i), rf_wdata, 32'(vt[i].x_wd));
            end
            tick($sformatf("vec%0d", i));
        end

        // Load-use dependency on a long load
        idle(); issue(1, 5, 0, 0); tick("t1_load");
        idle(); issue(0, 6, 5, 1);
        #1; check("t1.raw_stall", 32'(id_stall), 1);
        tick("t1_wait0");
        tick("t1_wait1");
        lat_valid = 1; lat_addr = 5'd5; lat_data = 32'hDEADBEEF;
        #1;
        check("t1.rf_waddr", 32'(rf_waddr), 5);
        check("t1.rf_wdata", rf_wdata, 32'hDEADBEEF);
`ifdef WBSCHED_BYPASS_EN
        check("t1.bypass_fire", 32'(id_stall), 0);
        tick("t1_ret");
        idle();
`else
        check("t1.hs_still_stalled", 32'(id_stall), 1);
        tick("t1_ret");
        lat_valid = 0;
        #1; check("t1.fire_after", 32'(id_stall), 0);
        tick("t1_fire");
        idle();
`endif
        tick("t1_idle");

        // Starvation drain
        idle();
        pipe_wb_valid = 1; pipe_wb_addr = 5'd10; pipe_wb_data = 32'h1234;
        lat_valid = 1; lat_addr = 5'd12; lat_data = 32'h5678;
        id_valid = 1;
        for (int c = 0; c < 4; c++) tick($sformatf("t3_block%0d", c));
        #1; check("t3.drain_stall", 32'(id_stall), 1);
        tick("t3_drain");
        pipe_wb_valid = 0;
        #1;
        check("t3.lat_ready", 32'(lat_ready), 1);
        check("t3.rf_waddr", 32'(rf_waddr), 12);
        tick("t3_hs");
        lat_valid = 0;
        #1; check("t3.idle_stall", 32'(id_stall), 0);
        tick("t3_idle");

        // Outstanding limit
        for (int r = 1; r <= 4; r++) begin
            idle(); issue(1, r, 0, 0); tick($sformatf("t4_issue%0d", r));
        end
        idle(); issue(1, 9, 0, 0);
        #1;
        check("t4.busy", 32'(busy), 1);
        check("t4.full_stall", 32'(id_stall), 1);
        tick("t4_full");
        lat_valid = 1; lat_addr = 5'd2; lat_data = 32'h2;
        tick("t4_ret2");
        lat_valid = 0;
        #1; check("t4.released", 32'(id_stall), 0);
        tick("t4_fire9");
        idle();
        foreach (vt[k]) if (k < 4) begin
            lat_valid = 1; lat_addr = AW'(k == 0 ? 1 : (k == 1 ? 3 : (k == 2 ? 4 : 9)));
            lat_data = DW'(k); tick($sformatf("t4_drain%0d", k));
        end
        idle();
        #1; check("t4.empty", 32'(busy), 0);
        tick("t4_empty");

        // Long op to x0 and return to x0
        idle(); issue(1, 0, 0, 0); tick("t5_x0");
        idle();
        lat_valid = 1; lat_addr = 5'd0; lat_data = 32'h99;
        #1;
        check("t5.busy", 32'(busy), 0);
        check("t5.lat_ready", 32'(lat_ready), 1);
        check("t5.rf_we", 32'(rf_we), 0);
        tick("t5_ret0");

        // Reset while draining with x5 pending
        idle(); issue(1, 5, 0, 0); tick("t6_load");
        idle(); issue(0, 6, 5, 1);
        pipe_wb_valid = 1; pipe_wb_addr = 5'd11; pipe_wb_data = 32'h77;
        lat_valid = 1; lat_addr = 5'd5; lat_data = 32'h55;
        for (int c = 0; c < 4; c++) tick($sformatf("t6_block%0d", c));
        #1; rst = 1; #1;
        check("t6.rst_stall", 32'(id_stall), 0);
        check("t6.rst_lat_ready", 32'(lat_ready), 0);
        check("t6.rst_rf_we", 32'(rf_we), 0);
        check("t6.rst_waddr", 32'(rf_waddr), 0);
        check("t6.rst_wdata", rf_wdata, 0);
        check("t6.rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        idle(); issue(0, 6, 5, 1);
        #1;
        check("t6.after_stall", 32'(id_stall), 0);
        check("t6.after_busy", 32'(busy), 0);
        tick("t6_after");

        // Random traffic against the reference
        for (int n = 0; n < 2000; n++) begin
            idle();
            id_valid = 1'($urandom_range(0, 1));
            id_rs1_addr = AW'($urandom_range(0, 7)); id_rs1_used = 1'($urandom_range(0, 1));
            id_rs2_addr = AW'($urandom_range(0, 7)); id_rs2_used = 1'($urandom_range(0, 1));
            id_rd_addr = AW'($urandom_range(0, 7)); id_rd_we = 1'($urandom_range(0, 1));
            id_long = ($urandom_range(0, 2) == 0);
            pipe_wb_valid = 1'($urandom_range(0, 1));
            pipe_wb_addr = AW'($urandom); pipe_wb_data = $urandom;
            lat_valid = (outq.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            if (outq.size() != 0 && $urandom_range(0, 3) != 0)
                lat_addr = AW'(outq[$urandom_range(0, outq.size() - 1)]);
            else
                lat_addr = AW'($urandom_range(0, 7));
            lat_data = $urandom;
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
